// File: rtl/sunc_fifo.sv
// Single-clock FIFO of DEPTH x WIDTH words; registered read data appears one clock after an accepted RD_EN.
// Writes while full are dropped unless a read frees a slot on the same edge; reads while empty are ignored.
module sunc_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             WR_EN,
   input  logic [WIDTH-1:0] data_in,
   input  logic             RD_EN,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             wr_ok, rd_ok;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));
   assign data_out = dout_q;

   // A read on the same edge frees the slot, so a full FIFO still takes the write.
   assign wr_ok = WR_EN && (!full || RD_EN);
   assign rd_ok = RD_EN && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      if (wr_ok) begin
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (rd_ok) begin
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
         dout_d   = mem_q[rd_ptr_q];
      end
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

endmodule

// File: tb/tb_sunc_fifo.sv
// Bench for sunc_fifo: directed and random strobes against a queue-based reference, checked by a negedge monitor.
module tb_sunc_fifo;
   localparam int DEPTH = 8;
   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             WR_EN = 1'b0;
   logic             RD_EN = 1'b0;
   logic [WIDTH-1:0] data_in = '0;
   logic [WIDTH-1:0] data_out;
   logic             full, empty;

   always #5 clk = ~clk;

   sunc_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .WR_EN(WR_EN), .data_in(data_in),
      .RD_EN(RD_EN), .data_out(data_out), .full(full), .empty(empty)
   );

   int total = 0;
   int bad   = 0;
   logic [WIDTH-1:0] mdl_q [$];  // words held by the reference FIFO
   logic [WIDTH-1:0] exp_q [$];  // data_out values due on the next monitor sample
   logic [WIDTH-1:0] last_dout = '0;
   bit started = 1'b0;

   function automatic void check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endfunction

   // Drive one cycle, then advance the reference model on the same rising edge.
   task automatic step(input bit r, input bit w, input logic [WIDTH-1:0] d, input bit rd);
      bit wa, ra;
      rst = r; WR_EN = w; data_in = d; RD_EN = rd;
      @(posedge clk);
      if (r) begin
         mdl_q.delete();
         exp_q.delete();
         exp_q.push_back('0);
         started = 1'b1;
      end else begin
         wa = w && ((mdl_q.size() < DEPTH) || rd);
         ra = rd && (mdl_q.size() > 0);
         if (ra) exp_q.push_back(mdl_q.pop_front());
         if (wa) mdl_q.push_back(d);
      end
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (started) begin
         if (exp_q.size() > 0) begin
            last_dout = exp_q.pop_front();
            check("rd_data", data_out, last_dout);
         end else begin
            check("dout_hold", data_out, last_dout);
         end
         check("empty", {31'd0, empty}, {31'd0, mdl_q.size() == 0});
         check("full", {31'd0, full}, {31'd0, mdl_q.size() == DEPTH});
      end
   end

   initial begin
      @(negedge clk);
      step(1, 0, '0, 0);
      step(0, 0, '0, 1);
      step(0, 0, '0, 1);
      // overfill then drain one past empty
      for (int i = 1; i <= 10; i++) step(0, 1, 32'hA000_0000 + i, 0);
      for (int i = 0; i < 9; i++) step(0, 0, '0, 1);
      // wrap-around
      for (int i = 0; i < 5; i++) step(0, 1, 32'hC000_0000 + i, 0);
      for (int i = 0; i < 5; i++) step(0, 0, '0, 1);
      for (int i = 0; i < 8; i++) step(0, 1, 32'hB0 + i, 0);
      for (int i = 0; i < 8; i++) step(0, 0, '0, 1);
      // simultaneous access at partial, full and empty occupancy
      for (int i = 0; i < 3; i++) step(0, 1, 32'hD000_0000 + i, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 32'hD100_0000 + i, 1);
      for (int i = 0; i < 5; i++) step(0, 1, 32'hD200_0000 + i, 0);
      step(0, 1, 32'hD300_0000, 1);
      for (int i = 0; i < 8; i++) step(0, 0, '0, 1);
      step(0, 1, 32'hD400_0000, 1);
      step(0, 0, '0, 1);
      // reset mid-operation
      for (int i = 0; i < 4; i++) step(0, 1, 32'hE000_0000 + i, 0);
      step(1, 0, '0, 0);
      step(0, 1, 32'hE100_0000, 0);
      step(0, 0, '0, 1);
      // random traffic with occasional reset
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 55, $urandom,
              $urandom_range(0, 99) < 50);
      end
      step(0, 0, '0, 0);
      step(0, 0, '0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
